// File: rtl/vedic_pkg.sv
// Shared widths and types for the pipelined 8x8 Vedic multiplier.
package vedic_pkg;
  localparam int VEDIC_W   = 8;
  localparam int VEDIC_PW  = 16;
  localparam int VEDIC_NIB = 4;
  localparam int VEDIC_LAT = 3;

  typedef logic [VEDIC_W-1:0]  operand_t;
  typedef logic [VEDIC_PW-1:0] product_t;
  typedef logic [VEDIC_W-1:0]  pp_t;
endpackage

// File: rtl/vedic_pp_4x4.sv
// Combinational 4x4 Urdhva-Tiryagbhyam multiplier: vertical/crosswise column sums,
// then weighted merge of the columns into an 8-bit product.
module vedic_pp_4x4
  import vedic_pkg::*;
(
  input  logic [VEDIC_NIB-1:0] i_a,
  input  logic [VEDIC_NIB-1:0] i_b,
  output pp_t                  o_p
);

  // Column k gathers every bit product a[i]*b[j] with i+j == k (at most 4 terms).
  function automatic logic [2:0] col_sum(input logic [3:0] a, input logic [3:0] b, input int k);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      if ((k - i) >= 0 && (k - i) < 4) s = s + {2'b00, a[i] & b[k-i]};
    return s;
  endfunction

  logic [2:0] w_col [7];

  for (genvar k = 0; k < 7; k++) begin : g_col
    assign w_col[k] = col_sum(i_a, i_b, k);
  end

  always_comb begin
    o_p = '0;
    for (int k = 0; k < 7; k++) o_p = o_p + (pp_t'(w_col[k]) << k);
  end

endmodule

// File: rtl/vedic_mul8_pipe.sv
// Three-stage 8x8 Vedic multiplier with valid/ready on both sides.
// Optional saturating output-transfer counter: define VEDIC_MUL8_CNT_EN.
module vedic_mul8_pipe
  import vedic_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_p,
  output logic          busy
`ifdef VEDIC_MUL8_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [15:0]   prod_cnt
`endif
);

  if (W != VEDIC_W || PW != 2 * W) begin : g_param_chk
    $error("vedic_mul8_pipe supports only W=8, PW=16");
  end

  logic [3:1]          r_vld_pipe;
  logic [3:0]          w_vld;
  logic [3:1]          w_rdy;
  logic [3:0][W-1:0]   w_q;
  logic [3:0][W-1:0]   r_q;
  logic [3:0]          r_lo;
  logic [8:0]          r_mid;
  logic [3:0]          r_hq0;
  pp_t                 r_hi;
  product_t            r_p;
  logic [9:0]          w_m;
  pp_t                 w_p_hi;

  assign w_vld = {r_vld_pipe, in_valid};

  // Readiness ripples back combinationally so a full pipe still streams at 1/cycle.
  assign w_rdy[3] = ~r_vld_pipe[3] | out_ready;
  assign w_rdy[2] = ~r_vld_pipe[2] | w_rdy[3];
  assign w_rdy[1] = ~r_vld_pipe[1] | w_rdy[2];

  assign in_ready  = w_rdy[1];
  assign out_valid = r_vld_pipe[3];
  assign out_p     = r_p;
  assign busy      = |r_vld_pipe;

  // q[k]: a nibble k[0], b nibble k[1] -> q0=aL*bL, q1=aH*bL, q2=aL*bH, q3=aH*bH.
  for (genvar k = 0; k < 4; k++) begin : g_pp
    vedic_pp_4x4 u_pp (
      .i_a (in_a[VEDIC_NIB*(k%2) +: VEDIC_NIB]),
      .i_b (in_b[VEDIC_NIB*(k/2) +: VEDIC_NIB]),
      .o_p (w_q[k])
    );
  end

  assign w_m    = {1'b0, r_mid} + {6'b0, r_hq0};
  // Carry out of the top byte is always zero: max product 0xFE01 fits in 16 bits.
  assign w_p_hi = r_hi + {2'b00, w_m[9:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      for (int k = 1; k <= 3; k++)
        if (w_rdy[k]) r_vld_pipe[k] <= w_vld[k-1];
    end
  end

  // Data only moves with a valid token, so out_p holds the last product when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_lo  <= '0;
      r_mid <= '0;
      r_hq0 <= '0;
      r_hi  <= '0;
      r_p   <= '0;
    end else begin
      if (w_rdy[1] && w_vld[0]) r_q <= w_q;
      if (w_rdy[2] && w_vld[1]) begin
        r_lo  <= r_q[0][3:0];
        r_mid <= {1'b0, r_q[1]} + {1'b0, r_q[2]};
        r_hq0 <= r_q[0][7:4];
        r_hi  <= r_q[3];
      end
      if (w_rdy[3] && w_vld[2]) r_p <= {w_p_hi, w_m[3:0], r_lo};
    end
  end

`ifdef VEDIC_MUL8_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               r_cnt <= '0;
    else if (cnt_clr)                                         r_cnt <= '0;
    else if (out_valid && out_ready && (r_cnt != 16'hFFFF))   r_cnt <= r_cnt + 16'd1;
  end

  assign prod_cnt = r_cnt;
`endif

endmodule

// File: doc/vedic_mul8_pipe.md
Name: vedic_mul8_pipe

Overview:
- Pipelined 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready handshakes on both sides.
- Splits the operands into nibbles, forms four 4x4 partial products, then merges them through registered adder stages.
- The final stage includes the 6-bit high-part addition.
- Sits between the operand source and the product consumer (accumulator/datapath); it wraps the team's combinational adders with pipeline registers and backpressure.

Parameters:
- W, 8, operand width; only 8 is supported, and the block fails elaboration otherwise.
- PW, 16, product width; fixed at 2*W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset, deasserted synchronously externally.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a  in  8  multiplicand, unsigned.
- in_b  in  8  multiplier, unsigned.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts the product this cycle.
- out_p  out  16  product in_a*in_b.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid and in_ready are both high on a rising edge.
  - Output transfer occurs when out_valid and out_ready are both high on a rising edge.
- Three register stages S1, S2, S3, each with a valid bit v1, v2, v3. S3 drives out_p and out_valid (out_valid = v3).
- Stage readiness: rdy3 = ~v3 | out_ready; rdy2 = ~v2 | rdy3; rdy1 = ~v1 | rdy2; in_ready = rdy1. This is combinational from out_ready, with no bubble insertion.
- S1 (on input transfer): registers the partial products.
  - q0 = a[3:0]*b[3:0]
  - q1 = a[7:4]*b[3:0]
  - q2 = a[3:0]*b[7:4]
  - q3 = a[7:4]*b[7:4]
  - Each is 8 bits.
- S2 (when rdy2): registers
  - lo = q0[3:0]
  - mid = q1 + q2 (9 bits, carry kept)
  - hq0 = q0[7:4]
  - hi = q3
- S3 (when rdy3): computes
  - m = mid + hq0 (10 bits, no overflow possible)
  - out_p = {hi + m[9:4], m[3:0], lo}
  - The top addition is a 6-bit m[9:4] added to an 8-bit hi into 8 bits; the final carry is provably zero and is discarded.
- Valid bits:
  - A stage's valid loads the upstream valid when the stage is ready.
  - Otherwise it holds; data holds with it.
  - Data registers may load freely when their valid is 0, but must not change while a stage is valid and not ready.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput: 1 product per cycle.
- Backpressure: with out_ready low, the pipe fills to 3 entries, then in_ready drops. No product is lost, duplicated or reordered.
- Simultaneous output and input transfer with a full pipe: all stages advance in the same edge and in_ready stays high.
- Reset values (async assertion): v1 = v2 = v3 = 0, out_valid = 0, out_p = 0, busy = 0, all data registers = 0. in_ready = 1 once reset is released.
- Reset mid-operation: all in-flight products are discarded and none emerge after release.
- busy = v1 | v2 | v3.
- Boundary values: 0xFF*0xFF = 0xFE01 and 0*x = 0 must be exact.

Optional Feature:
- Macro VEDIC_MUL8_CNT_EN.
- When defined:
  - Adds output port prod_cnt (16 bits): a saturating count of output transfers, reset to 0, sticking at 0xFFFF.
  - Adds input port cnt_clr (1 bit): synchronous clear, which takes priority over an increment in the same cycle.
- When undefined: neither port nor the counter logic exists, and the block's behaviour is otherwise identical.

Decomposition:
- Package vedic_pkg holds:
  - constants VEDIC_W = 8, VEDIC_PW = 16, VEDIC_NIB = 4, VEDIC_LAT = 3
  - typedef operand_t (8 bits), product_t (16 bits), pp_t (8 bits)
- One sub-module, vedic_pp_4x4: a combinational 4x4 Vedic multiplier producing an 8-bit result, instantiated four times in S1.
- Adders stay inline or reuse the existing adder modules.

Test Plan:
- Single op, out_ready = 1: a = 0x0D, b = 0x0B. Response: out_valid rises exactly 3 cycles after acceptance, out_p = 0x008F, busy falls one cycle later.
- Corners, back-to-back: (0xFF,0xFF), (0x00,0xA5), (0x80,0x02), (0x01,0xFF). Response: outputs 0xFE01, 0x0000, 0x0100, 0x00FF in order on consecutive cycles.
- Stall: stream 5 ops with out_ready = 0. Response: in_ready low after 3 accepted, out_p held stable; release out_ready and all 5 emerge in order, no gaps, correct values.
- Reset mid-flight: assert rst_n = 0 with 3 ops in flight. Response: out_valid = 0 and out_p = 0 immediately (async); after release, no stale product appears within 10 cycles.
- Random: 10k random operand pairs with random out_ready/in_valid toggling. Scoreboard: every out_p equals a*b, count matches, order is preserved.
- With VEDIC_MUL8_CNT_EN:
  - Preload the counter to 0xFFFE through 0xFFFE transfers (or a force); after 3 more transfers, prod_cnt = 0xFFFF.
  - cnt_clr asserted together with a transfer gives prod_cnt = 0.
